exe_mdu_ctrl: RTL and testbench
===============================

EXE_MDU_CTRL -- requirements
Module: exe_mdu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: clrn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: start  in  1  issue MULT/MULTU/DIV/DIVU from EXE stage.
REQ-004 SHALL have ports: op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports: a, b  in  32 each  rs (multiplicand/dividend), rt (multiplier/divisor).
REQ-006 SHALL have ports: cancel  in  1  pipeline flush; aborts the operation in progress.
REQ-007 SHALL have ports: hi_we, lo_we  in  1 each  MTHI/MTLO strobes; wdata  in  32  write data.
REQ-008 SHALL have ports: stall  out  1  freezes IF/ID/EXE; done  out  1  one-cycle completion pulse.
REQ-009 SHALL have ports: dz  out  1  divide-by-zero pulse, coincident with done; hi, lo  out  32 each  registered HI/LO.
REQ-010 SHALL use one clock, clk; reset SHALL be asynchronous and active-low on clrn.

Function
REQ-011 SHALL implement states IDLE, PREP, RUN, FIX, DONE.
REQ-012 SHALL accept start only in IDLE or DONE and go to PREP; start in any other state SHALL be ignored.
REQ-013 PREP SHALL latch the operands, converting them to 33-bit magnitudes for signed ops (op[0]=0) and zero-extending them for unsigned ops, and SHALL record the result signs.
REQ-014 RUN SHALL last exactly 32 cycles, counted by a 5-bit counter from 0 to 31, performing one shift-add (multiply) or restoring shift-subtract (divide) step per cycle through one shared 33-bit adder.
REQ-015 FIX SHALL negate the results as required and write HI/LO at the edge leaving FIX: multiply HI:LO = 64-bit product; divide LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-016 With start sampled in cycle 0, the block SHALL be in PREP in cycle 1, RUN in cycles 2-33, FIX in cycle 34, and SHALL assert done in cycle 35 (DONE) with the new HI/LO visible.
REQ-017 stall SHALL be the combinational value (start AND state in {IDLE,DONE}) OR state in {PREP,RUN,FIX}; stall SHALL be low in DONE unless a new start is presented.
REQ-018 Divide with b=0 SHALL go PREP->DONE, leave HI/LO unchanged, and assert dz and done in cycle 2.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL produce LO=0x80000000 and HI=0 with no dz.
REQ-020 cancel SHALL force the next state to IDLE from any state, leave HI/LO unchanged, suppress done, and SHALL take priority over a simultaneous start.
REQ-021 hi_we/lo_we SHALL take effect only in IDLE or DONE; in DONE the explicit write SHALL override the just-written result; in other states they SHALL be ignored.

Reset
REQ-022 Asserting clrn low SHALL set state=IDLE, counter=0, hi=lo=0, and done=dz=0 immediately, including in the middle of an operation.
REQ-023 Deasserting clrn SHALL not start an operation; the first operation SHALL need a fresh start.

Configuration
REQ-024 Macro EXE_MDU_DIV_EN defined SHALL include the divide datapath as specified.
REQ-025 Without EXE_MDU_DIV_EN, DIV/DIVU SHALL go PREP->DONE, leave HI/LO unchanged, pulse done in cycle 2 with dz=0, and synthesize no divide logic; multiply SHALL be unchanged.

Structure
REQ-026 Package exe_mdu_pkg SHALL hold the op codes MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU, the state encoding, and MDU_ITER=32.
REQ-027 The shared 33-bit adder/subtractor SHALL be sub-module mdu_addsub33 (inputs x, y, sub; outputs sum, carry); all other logic SHALL stay in exe_mdu_ctrl.

Verification
REQ-028 MULT a=0xFFFFFFFE (-2), b=3 -> done in cycle 35, hi=0xFFFFFFFF, lo=0xFFFFFFFA, stall high in cycles 0-34.
REQ-029 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> dz=done=1 in cycle 2, HI/LO unchanged.
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, dz=0.
REQ-032 MULT started, cancel in cycle 10 -> IDLE in cycle 11, no done, HI/LO unchanged; start+cancel in the same cycle -> stays IDLE.
REQ-033 clrn pulsed low in cycle 20 of a DIVU -> hi=lo=0 and stall=0 immediately; a back-to-back start in DONE -> second done 35 cycles after the second start.

Source files
------------

// File: rtl/exe_mdu_pkg.sv
// exe_mdu_pkg: op codes, FSM encoding and iteration count shared by the HI/LO
// multiply/divide unit and its adder.
package exe_mdu_pkg;
  localparam int MDU_ITER = 32;
  localparam int MDU_AW   = 33;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;
endpackage

// File: rtl/mdu_addsub33.sv
// mdu_addsub33: 33-bit adder/subtractor shared by the multiply and divide steps.
// carry is the carry-out; on subtract it is high when x >= y (no borrow).
module mdu_addsub33
  import exe_mdu_pkg::*;
(
  input  logic [MDU_AW-1:0] x,
  input  logic [MDU_AW-1:0] y,
  input  logic              sub,
  output logic [MDU_AW-1:0] sum,
  output logic              carry
);
  logic [MDU_AW-1:0] y_eff;

  assign y_eff = sub ? ~y : y;
  assign {carry, sum} = {1'b0, x} + {1'b0, y_eff} + {{MDU_AW{1'b0}}, sub};
endmodule

// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Define EXE_MDU_DIV_EN to build the restoring-divide datapath.
module exe_mdu_ctrl
  import exe_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        dz,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  mdu_state_e  state, state_nx;
  logic [4:0]  cnt;
  logic [32:0] ph, md, ph_step;
  logic [31:0] pl, pl_step;
  logic        neg_q;
  logic [32:0] add_x, add_y, add_sum;
  logic        add_sub, add_co;
  logic        is_div, is_sgn, a_neg, b_neg, idle_or_done;
  logic [31:0] mag_a, mag_b, res_hi, res_lo;
  logic [63:0] prod;
`ifdef EXE_MDU_DIV_EN
  logic        div_r, neg_r, dz_r;
`endif

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign is_div       = (op == MDU_DIV) || (op == MDU_DIVU);
  assign is_sgn       = (op == MDU_MULT) || (op == MDU_DIV);
  assign a_neg        = is_sgn & a[31];
  assign b_neg        = is_sgn & b[31];
  // 32-bit two's-complement negation also yields the right magnitude for 0x80000000.
  assign mag_a        = a_neg ? neg32(a) : a;
  assign mag_b        = b_neg ? neg32(b) : b;
  assign idle_or_done = (state == ST_IDLE) || (state == ST_DONE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_PREP;
`ifdef EXE_MDU_DIV_EN
      ST_PREP: state_nx = (is_div && (b == 32'd0)) ? ST_DONE : ST_RUN;
`else
      ST_PREP: state_nx = is_div ? ST_DONE : ST_RUN;
`endif
      ST_RUN:  if (cnt == 5'(MDU_ITER - 1)) state_nx = ST_FIX;
      ST_FIX:  state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_PREP : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (cancel) state_nx = ST_IDLE;
  end

  always_comb begin
    stall = (start && idle_or_done) || (state inside {ST_PREP, ST_RUN, ST_FIX});
    done  = (state == ST_DONE);
`ifdef EXE_MDU_DIV_EN
    dz    = (state == ST_DONE) && dz_r;
`else
    dz    = 1'b0;
`endif
  end

  // Multiply adds md into the high half when the multiplier LSB is set; divide
  // trial-subtracts the divisor from the remainder shifted left by one dividend bit.
`ifdef EXE_MDU_DIV_EN
  assign add_sub = div_r;
  assign add_x   = div_r ? {ph[31:0], pl[31]} : ph;
  assign add_y   = (div_r || pl[0]) ? md : 33'd0;
`else
  assign add_sub = 1'b0;
  assign add_x   = ph;
  assign add_y   = pl[0] ? md : 33'd0;
`endif

  mdu_addsub33 u_addsub (
    .x     (add_x),
    .y     (add_y),
    .sub   (add_sub),
    .sum   (add_sum),
    .carry (add_co)
  );

  always_comb begin
    ph_step = {add_co, add_sum[32:1]};
    pl_step = {add_sum[0], pl[31:1]};
`ifdef EXE_MDU_DIV_EN
    if (div_r) begin
      ph_step = add_co ? add_sum : add_x;
      pl_step = {pl[30:0], add_co};
    end
`endif
  end

  assign prod = neg_q ? neg64({ph[31:0], pl}) : {ph[31:0], pl};

  always_comb begin
    {res_hi, res_lo} = prod;
`ifdef EXE_MDU_DIV_EN
    if (div_r) begin
      res_lo = neg_q ? neg32(pl) : pl;
      res_hi = neg_r ? neg32(ph[31:0]) : ph[31:0];
    end
`endif
  end

  // PREP boundary: operands become magnitudes; RUN boundary: one step per cycle.
  always_ff @(posedge clk) begin
    if (state == ST_PREP) begin
      ph    <= 33'd0;
      neg_q <= a_neg ^ b_neg;
`ifdef EXE_MDU_DIV_EN
      neg_r <= a_neg;
      pl    <= is_div ? mag_a : mag_b;
      md    <= {1'b0, is_div ? mag_b : mag_a};
`else
      pl    <= mag_b;
      md    <= {1'b0, mag_a};
`endif
    end else if (state == ST_RUN) begin
      ph <= ph_step;
      pl <= pl_step;
    end
  end

  // FIX boundary: signed results land in HI/LO unless the op is flushed.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt <= 5'd0;
      hi  <= 32'd0;
      lo  <= 32'd0;
`ifdef EXE_MDU_DIV_EN
      dz_r  <= 1'b0;
      div_r <= 1'b0;
`endif
    end else begin
      if (state == ST_PREP)     cnt <= 5'd0;
      else if (state == ST_RUN) cnt <= cnt + 5'd1;
      if (state == ST_FIX && !cancel) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      if (idle_or_done && hi_we) hi <= wdata;
      if (idle_or_done && lo_we) lo <= wdata;
`ifdef EXE_MDU_DIV_EN
      if (state == ST_PREP) begin
        dz_r  <= is_div && (b == 32'd0);
        div_r <= is_div;
      end
`endif
    end
  end
endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// Bench for exe_mdu_ctrl: directed corner cases plus randomized traffic checked
// every cycle against a transaction-level model of the multiply/divide unit.
`timescale 1ns/1ps
module tb_exe_mdu_ctrl;
`ifdef EXE_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] rh;
    logic [31:0] rl;
    logic        dz;
    logic        wr;
    logic [5:0]  len;
  } res_t;

  logic        clk = 1'b0, clrn = 1'b1, start = 1'b0, cancel = 1'b0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        stall, done, dz;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  exe_mdu_ctrl dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .stall(stall), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from 64-bit arithmetic.
  function automatic res_t calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    longint sx, sy, q, rm;
    longint unsigned ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    r = '0;
    r.wr = 1'b1;
    r.len = 6'd35;
    if (o == 2'd0) begin
      p = sx * sy;
      r.rh = p[63:32]; r.rl = p[31:0];
    end else if (o == 2'd1) begin
      p = ux * uy;
      r.rh = p[63:32]; r.rl = p[31:0];
    end else if (!DIV_EN || y == 32'd0) begin
      r.wr = 1'b0;
      r.len = 6'd2;
      r.dz = DIV_EN && (y == 32'd0);
    end else if (o == 2'd2) begin
      q = sx / sy; rm = sx % sy;
      r.rl = q[31:0]; r.rh = rm[31:0];
    end else begin
      p = ux / uy; r.rl = p[31:0];
      p = ux % uy; r.rh = p[31:0];
    end
    return r;
  endfunction

  // Model: busy for len cycles after an accepted start, then a one-cycle done.
  bit          m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  int          m_k = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  res_t        p = '0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0; m_k <= 0;
      m_hi <= 32'd0; m_lo <= 32'd0;
    end else begin
      if (!m_busy && hi_we) m_hi <= wdata;
      if (!m_busy && lo_we) m_lo <= wdata;
      if (cancel) begin
        m_busy <= 1'b0; m_done <= 1'b0;
      end else if (m_busy) begin
        m_k <= m_k + 1;
        if (m_k + 1 == int'(p.len)) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_dz <= p.dz;
          if (p.wr) begin m_hi <= p.rh; m_lo <= p.rl; end
        end
      end else if (start) begin
        p <= calc(op, a, b); m_busy <= 1'b1; m_k <= 1; m_done <= 1'b0;
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_stall", 32'(stall), 32'(m_busy | start));
      chk("cyc_done",  32'(done),  32'(m_done));
      chk("cyc_dz",    32'(dz),    32'(m_done & m_dz));
      chk("cyc_hi",    hi, m_hi);
      chk("cyc_lo",    lo, m_lo);
    end
  end

  task automatic step_cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string nm, input int max, output int cyc);
    cyc = -1;
    for (int k = 1; k <= max; k++) begin
      step_cyc();
      start = 1'b0;
      if (done) begin cyc = k; break; end
    end
    if (cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within %0d cycles", nm, max);
    end
  endtask

  task automatic expect_quiet(input string nm, input int ncyc);
    int seen = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (done || stall) seen++;
      step_cyc();
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
  endtask

  res_t        r;
  int          lat;
  logic [31:0] e_hi, e_lo;
  logic [1:0]  long_op;

  initial begin
    #1 clrn = 1'b0; chk_on = 1'b1;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done | dz), 32'd0);

    r = calc(2'd0, 32'hFFFFFFFE, 32'd3);
    chk("model_mult_hi", r.rh, 32'hFFFFFFFF);
    chk("model_mult_lo", r.rl, 32'hFFFFFFFA);
    r = calc(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("model_multu_hi", r.rh, 32'hFFFFFFFE);
    chk("model_multu_lo", r.rl, 32'h00000001);
    r = calc(2'd2, 32'hFFFFFFF9, 32'd2);
    chk("model_div_lo", r.rl, DIV_EN ? 32'hFFFFFFFD : 32'd0);
    chk("model_div_hi", r.rh, DIV_EN ? 32'hFFFFFFFF : 32'd0);
    r = calc(2'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("model_ovf_lo", r.rl, DIV_EN ? 32'h80000000 : 32'd0);
    r = calc(2'd3, 32'd7, 32'd0);
    chk("model_dz", 32'(r.dz), 32'(DIV_EN));
    chk("model_dz_len", 32'(r.len), 32'd2);

    @(posedge clk); #1 clrn = 1'b1;
    expect_quiet("rst_nostart", 3);

    // MULT -2*3 with exact cycle-by-cycle stall/done
    issue(2'd0, 32'hFFFFFFFE, 32'd3);
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      chk("mult_stall", 32'(stall), 32'(k <= 34));
      chk("mult_done", 32'(done), 32'(k == 35));
      if (k == 35) begin
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFFA);
      end
      step_cyc();
      start = 1'b0;
    end

    issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu", 40, lat);
    chk("multu_lat", 32'(lat), 32'd35);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);
    e_hi = DIV_EN ? 32'hFFFFFFFF : 32'hFFFFFFFE;
    e_lo = DIV_EN ? 32'hFFFFFFFD : 32'h00000001;
    step_cyc();

    issue(2'd2, 32'hFFFFFFF9, 32'd2);
    wait_done("div", 40, lat);
    chk("div_lat", 32'(lat), DIV_EN ? 32'd35 : 32'd2);
    chk("div_hi", hi, e_hi);
    chk("div_lo", lo, e_lo);
    chk("div_dz", 32'(dz), 32'd0);
    step_cyc();

    issue(2'd3, 32'd7, 32'd0);
    wait_done("divu_dz", 40, lat);
    chk("divu_dz_lat", 32'(lat), 32'd2);
    chk("divu_dz_flag", 32'(dz), 32'(DIV_EN));
    chk("divu_dz_hi", hi, e_hi);
    chk("divu_dz_lo", lo, e_lo);
    step_cyc();

    issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_ovf", 40, lat);
    chk("div_ovf_lo", lo, DIV_EN ? 32'h80000000 : e_lo);
    chk("div_ovf_hi", hi, DIV_EN ? 32'd0 : e_hi);
    chk("div_ovf_dz", 32'(dz), 32'd0);
    step_cyc();

    hi_we = 1'b1; wdata = 32'h12345678; step_cyc();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABCDEF0; step_cyc();
    lo_we = 1'b0;
    @(negedge clk);
    chk("mthi", hi, 32'h12345678);
    chk("mtlo", lo, 32'h9ABCDEF0);
    step_cyc();

    // flush in cycle 10 of a MULT
    issue(2'd0, 32'd5, 32'd7);
    for (int k = 0; k < 10; k++) begin step_cyc(); start = 1'b0; end
    cancel = 1'b1; step_cyc(); cancel = 1'b0;
    @(negedge clk);
    chk("cancel_idle", 32'(stall), 32'd0);
    step_cyc();
    expect_quiet("cancel_nodone", 40);
    chk("cancel_hi", hi, 32'h12345678);
    chk("cancel_lo", lo, 32'h9ABCDEF0);

    issue(2'd1, 32'd9, 32'd9); cancel = 1'b1; step_cyc();
    start = 1'b0; cancel = 1'b0;
    expect_quiet("start_cancel", 40);

    // explicit MTLO in DONE overrides the fresh product
    issue(2'd0, 32'd2, 32'd3);
    wait_done("override", 40, lat);
    lo_we = 1'b1; wdata = 32'hCAFEF00D; step_cyc(); lo_we = 1'b0;
    @(negedge clk);
    chk("override_lo", lo, 32'hCAFEF00D);
    chk("override_hi", hi, 32'd0);
    step_cyc();

    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("b2b_first", 40, lat);
    chk("b2b_first_lo", lo, 32'd1);
    issue(2'd1, 32'd10, 32'd20);
    wait_done("b2b_second", 40, lat);
    chk("b2b_lat", 32'(lat), 32'd35);
    chk("b2b_lo", lo, 32'd200);
    chk("b2b_hi", hi, 32'd0);
    step_cyc();

    hi_we = 1'b1; wdata = 32'hDEADBEEF; step_cyc(); hi_we = 1'b0;
    long_op = DIV_EN ? 2'd3 : 2'd1;
    issue(long_op, 32'd100, 32'd7);
    for (int k = 0; k < 20; k++) begin step_cyc(); start = 1'b0; end
    #2 clrn = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 clrn = 1'b1;
    expect_quiet("midrst_nostart", 40);

    for (int i = 0; i < 3000; i++) begin
      if (!m_busy && $urandom_range(0, 2) == 0) begin
        op = 2'($urandom_range(0, 3));
        a = $urandom;
        b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
          2: b = 32'($urandom_range(1, 5));
          3: a = 32'($urandom_range(0, 100));
          default: ;
        endcase
      end
      start  = ($urandom_range(0, 7) == 0);
      cancel = ($urandom_range(0, 79) == 0);
      hi_we  = ($urandom_range(0, 15) == 0);
      lo_we  = ($urandom_range(0, 15) == 0);
      wdata  = $urandom;
      step_cyc();
    end
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) step_cyc();
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
